ps2_scancode_receiver: RTL and testbench
========================================

Name: ps2_scancode_receiver

Overview:
PS/2 device-to-host serial receiver. It deserializes the keyboard's 11-bit frames on the ps2Clk/ps2Data pins into bytes and presents them on the scanCode/scanCodeReady interface consumed by the PS2KeyboardMemory key-state block. It sits between the board's PS/2 pins and PS2KeyboardMemory. It handles synchronization, clock-line glitch filtering, parity and stop checking, and mid-frame timeout recovery.

Parameters:
FILTER_LEN, 8, number of consecutive identical synchronized ps2Clk samples required to change the filtered clock level (range 2..32).
TIMEOUT_CYCLES, 100000, clk cycles allowed between filtered falling edges inside a frame before the frame is aborted (1 ms at 100 MHz).

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst  input  1  asynchronous, active-low reset.
ps2Clk  input  1  raw PS/2 clock pin, asynchronous to clk.
ps2Data  input  1  raw PS/2 data pin, asynchronous to clk.
scanCode  output  8  last correctly received byte; held stable between frames.
scanCodeReady  output  1  one-clk pulse, asserted in the same cycle scanCode takes a new value.
frameError  output  1  one-clk pulse on a parity error, stop-bit error or timeout abort.

Behaviour:
- Reset (rst=0, asynchronous): scanCode=8'h00, scanCodeReady=0, frameError=0, state=IDLE, counters=0. Synchronizers and the filtered clock reset to 1 (idle-high bus).
- Synchronization: ps2Clk and ps2Data each pass through a 2-flop synchronizer.
- Clock filter: clkF changes level only after FILTER_LEN consecutive synchronized ps2Clk samples of the opposite level. Shorter glitches are ignored.
- Fall event: the single cycle in which clkF goes 1->0. Data is sampled from synchronized ps2Data in that cycle.
- Frame format: start bit (0), 8 data bits LSB first, odd parity bit, stop bit (1).
- FSM transitions (all taken on fall events):
  - IDLE: sampled data 0 -> DATA with bitCnt=0. Sampled data 1 -> stay in IDLE (spurious edge, no error).
  - DATA: shift the sampled bit into shiftReg[bitCnt]. On bitCnt=7 -> PARITY; otherwise bitCnt+1.
  - PARITY: store the parity bit -> STOP.
  - STOP: parity is good when XOR of the 8 data bits and the parity bit equals 1.
    - Stop bit 1 and parity good: on the next clk edge scanCode<=shiftReg and scanCodeReady=1 for exactly 1 cycle.
    - Otherwise: frameError=1 for 1 cycle and scanCode is unchanged.
    - In both cases -> IDLE.
- Latency: scanCodeReady rises 1 clk after the fall event that samples the stop bit.
- Timeout:
  - In DATA, PARITY or STOP, a cycle counter resets on every fall event and increments otherwise.
  - When it reaches TIMEOUT_CYCLES: frameError pulses for 1 cycle, state -> IDLE, the partial byte is discarded and scanCode is unchanged.
  - The counter is idle and zero while in IDLE.
- Back-to-back frames: the byte-level protocol is passed through unmodified. Prefix bytes (E0, F0) are emitted as ordinary separate bytes; PS2KeyboardMemory decodes the sequences.
- Pulse exclusivity: scanCodeReady and frameError are never asserted in the same cycle.
- Reset mid-frame: the frame is abandoned, with no pulse output during or after reset. The next frame starting from a clean start bit is received normally.
- Host-to-device transmission is out of scope; the pins are input-only.

Test Plan:
1. Single frame 0x1C (bits 0,00111000,parity 0,1) at a 12 kHz PS/2 clock with clk=100 MHz -> one scanCodeReady pulse, scanCode=8'h1C, frameError never set.
2. Back-to-back frames F0 then 1C -> two ready pulses, scanCode=8'hF0 and then 8'h1C. Feeding the output into PS2KeyboardMemory makes the keyValue for ascii_a return to 0.
3. Frame 0x1C with parity bit 1 -> frameError pulses once, no scanCodeReady, scanCode keeps its previous value.
4. Frame with stop bit 0 -> frameError pulse, no ready. The next valid frame 0x12 -> scanCode=8'h12.
5. Start bit plus 4 data bits, then ps2Clk held high for over TIMEOUT_CYCLES -> frameError pulse at exactly TIMEOUT_CYCLES after the last fall event. The next frame 0x1C is received correctly.
6. ps2Clk low glitches of FILTER_LEN-1 clk cycles in IDLE and mid-frame -> ignored; the frame still decodes correctly. Separately, assert rst=0 mid-frame -> outputs go to reset values immediately, and the following frame decodes correctly.

Source files
------------

// File: rtl/ps2_scancode_receiver.sv
// PS/2 device-to-host receiver: synchronizes and glitch-filters the pins, then deserializes
// 11-bit frames into scan-code bytes with parity, stop and timeout checking.
module ps2_scancode_receiver #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [7:0] scanCode,
  output logic       scanCodeReady,
  output logic       frameError
);

  localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  logic [1:0]    ck_sync_q, dt_sync_q;
  logic          clkf_q, clkf_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    code_q, code_d;
  logic          ready_q, ready_d;
  logic          err_q, err_d;

  logic ck_s, sample, fall;

  assign ck_s   = ck_sync_q[1];
  assign sample = dt_sync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ck_sync_q <= '1;
      dt_sync_q <= '1;
    end else begin
      ck_sync_q <= {ck_sync_q[0], ps2Clk};
      dt_sync_q <= {dt_sync_q[0], ps2Data};
    end
  end

  // The filtered level flips on the FILTER_LEN-th consecutive opposite sample; any
  // agreeing sample restarts the run.
  always_comb begin
    clkf_d     = clkf_q;
    filt_cnt_d = '0;
    if (ck_s != clkf_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        clkf_d = ck_s;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  assign fall = clkf_q & ~clkf_d;

  // Timeout counter holds cycles elapsed since the last fall event (1 in the cycle after it),
  // so the abort pulse lands exactly TIMEOUT_CYCLES cycles after that fall.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    to_cnt_d  = '0;
    code_d    = code_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    if (state_q == S_IDLE) begin
      if (fall && !sample) begin
        state_d   = S_DATA;
        bit_cnt_d = '0;
        to_cnt_d  = TW'(1);
      end
    end else if (fall) begin
      to_cnt_d = TW'(1);
      case (state_q)
        S_DATA: begin
          shift_d[bit_cnt_q] = sample;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        S_PARITY: begin
          parity_d = sample;
          state_d  = S_STOP;
        end
        default: begin
          if (sample && ((^shift_q) ^ parity_q)) begin
            code_d  = shift_q;
            ready_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          to_cnt_d = '0;
          state_d  = S_IDLE;
        end
      endcase
    end else if (to_cnt_q >= TW'(TIMEOUT_CYCLES - 1)) begin
      err_d   = 1'b1;
      state_d = S_IDLE;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clkf_q     <= 1'b1;
      filt_cnt_q <= '0;
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      to_cnt_q   <= '0;
      code_q     <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clkf_q     <= clkf_d;
      filt_cnt_q <= filt_cnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      to_cnt_q   <= to_cnt_d;
      code_q     <= code_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
    end
  end

  assign scanCode      = code_q;
  assign scanCodeReady = ready_q;
  assign frameError    = err_q;

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Scoreboard bench for ps2_scancode_receiver: each frame pushes its expected pulse kind,
// code and output cycle; a monitor pops and compares whenever a pulse appears.
module tb_ps2_scancode_receiver;

  localparam int FL   = 8;
  localparam int TO   = 1500;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2Clk = 1'b1;
  logic       ps2Data = 1'b1;
  logic [7:0] scanCode;
  logic       scanCodeReady;
  logic       frameError;

  ps2_scancode_receiver #(
    .FILTER_LEN    (FL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2Clk       (ps2Clk),
    .ps2Data      (ps2Data),
    .scanCode     (scanCode),
    .scanCodeReady(scanCodeReady),
    .frameError   (frameError)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] code;
    int         cyc;
  } ev_t;

  ev_t        sb[$];
  ev_t        mon_e;
  logic [7:0] model_code = 8'h00;
  int         checks = 0;
  int         errors = 0;
  int         pulses = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (scanCodeReady || frameError) begin
        checks++; errors++;
        $display("FAIL pulse_in_reset ready=%b err=%b required 0 0", scanCodeReady, frameError);
      end
    end else if (scanCodeReady && frameError) begin
      checks++; errors++; pulses++;
      $display("FAIL exclusive ready=1 err=1 at cyc %0d", cyc);
    end else if (scanCodeReady || frameError) begin
      pulses++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse ready=%b err=%b code=%h at cyc %0d",
                 scanCodeReady, frameError, scanCode, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (frameError !== mon_e.is_err) begin
          errors++;
          $display("FAIL pulse_kind err=%b required %b", frameError, mon_e.is_err);
        end
        checks++;
        if (cyc !== mon_e.cyc) begin
          errors++;
          $display("FAIL pulse_cycle got %0d required %0d", cyc, mon_e.cyc);
        end
        if (!mon_e.is_err) model_code = mon_e.code;
        checks++;
        if (scanCode !== model_code) begin
          errors++;
          $display("FAIL scancode got %h required %h", scanCode, model_code);
        end
      end
    end
  end

  task automatic drive_bit(input logic b, input bit glitch, input bit push, input bit is_err,
                           input logic [7:0] code, output int c0);
    ev_t e;
    ps2Data = b;
    if (glitch) begin
      repeat (HALF / 2) @(negedge clk);
      ps2Clk = 1'b0;
      repeat (FL - 1) @(negedge clk);
      ps2Clk = 1'b1;
      repeat (HALF / 2) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    ps2Clk = 1'b0;
    c0 = cyc;
    if (push) begin
      e.is_err = is_err;
      e.code   = code;
      e.cyc    = c0 + FL + 2;
      sb.push_back(e);
    end
    repeat (HALF) @(negedge clk);
    ps2Clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input logic stop,
                            input int glitch_bit);
    logic [10:0] bits;
    int          c0;
    bit          ok;
    bits = {stop, (~^d) ^ bad_par, d, 1'b0};
    ok   = !bad_par && (stop === 1'b1);
    for (int i = 0; i < 11; i++) drive_bit(bits[i], i == glitch_bit, i == 10, !ok, d, c0);
    ps2Data = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required 0", sb.size());
      sb.delete();
    end
    repeat (HALF) @(negedge clk);
  endtask

  task automatic check_code(input logic [7:0] exp, input string name);
    checks++;
    if (scanCode !== exp) begin
      errors++;
      $display("FAIL %s scanCode=%h required %h", name, scanCode, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({scanCode, scanCodeReady, frameError} !== 10'h000) begin
      errors++;
      $display("FAIL reset_hold outputs=%h/%b/%b required 00/0/0", scanCode, scanCodeReady, frameError);
    end
    rst = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if ({scanCode, scanCodeReady, frameError} !== 10'h000) begin
      errors++;
      $display("FAIL reset_release outputs=%h/%b/%b required 00/0/0", scanCode, scanCodeReady, frameError);
    end
  endtask

  task automatic test_single();
    int p0 = pulses;
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    wait_drain(200);
    check_code(8'h1C, "single");
    checks++;
    if (pulses - p0 !== 1) begin
      errors++;
      $display("FAIL single_pulses got %0d required 1", pulses - p0);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(8'hF0, 1'b0, 1'b1, -1);
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    wait_drain(200);
    check_code(8'h1C, "back_to_back");
  endtask

  task automatic test_parity_error();
    send_frame(8'h5A, 1'b0, 1'b1, -1);
    send_frame(8'h1C, 1'b1, 1'b1, -1);
    wait_drain(200);
    check_code(8'h5A, "parity_hold");
  endtask

  task automatic test_stop_error();
    send_frame(8'h33, 1'b0, 1'b0, -1);
    wait_drain(200);
    check_code(8'h5A, "stop_hold");
    send_frame(8'h12, 1'b0, 1'b1, -1);
    wait_drain(200);
    check_code(8'h12, "after_stop_err");
  endtask

  task automatic test_timeout();
    logic [4:0] bits;
    int         c0;
    ev_t        e;
    bits = {4'b0110, 1'b0};
    for (int i = 0; i < 5; i++) drive_bit(bits[i], 1'b0, 1'b0, 1'b0, 8'h00, c0);
    ps2Data  = 1'b1;
    e.is_err = 1'b1;
    e.code   = 8'h00;
    e.cyc    = c0 + FL + 1 + TO;
    sb.push_back(e);
    wait_drain(TO + 200);
    check_code(8'h12, "timeout_hold");
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    wait_drain(200);
    check_code(8'h1C, "after_timeout");
  endtask

  task automatic test_glitch();
    int p0 = pulses;
    ps2Data = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2Clk = 1'b0;
    repeat (FL - 1) @(negedge clk);
    ps2Clk = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2Data = 1'b1;
    repeat (TO + 100) @(negedge clk);
    checks++;
    if (pulses !== p0) begin
      errors++;
      $display("FAIL idle_glitch pulses got %0d required %0d", pulses, p0);
    end
    send_frame(8'hA5, 1'b0, 1'b1, 5);
    send_frame(8'h3C, 1'b0, 1'b1, 9);
    wait_drain(200);
    check_code(8'h3C, "glitch_frames");
  endtask

  task automatic test_reset_midframe();
    int c0;
    int p0;
    drive_bit(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, c0);
    drive_bit(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, c0);
    drive_bit(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, c0);
    rst = 1'b0;
    #1;
    checks++;
    if ({scanCode, scanCodeReady, frameError} !== 10'h000) begin
      errors++;
      $display("FAIL midframe_reset outputs=%h/%b/%b required 00/0/0", scanCode, scanCodeReady, frameError);
    end
    model_code = 8'h00;
    p0 = pulses;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (TO + 100) @(negedge clk);
    checks++;
    if (pulses !== p0) begin
      errors++;
      $display("FAIL after_reset_pulses got %0d required %0d", pulses, p0);
    end
    send_frame(8'h12, 1'b0, 1'b1, -1);
    wait_drain(200);
    check_code(8'h12, "after_midframe_reset");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_parity_error();
    test_stop_error();
    test_timeout();
    test_glitch();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog cyc=%0d required completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
